// File: rtl/gpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpu_pkg: region codes, arbiter states, address-field positions      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package gpu_pkg;

  localparam int REGION_W = 4;

  // One-hot region codes, bit order {texture, tile, spirit, cr}
  localparam logic [REGION_W-1:0] REGION_CR      = 4'b0001;
  localparam logic [REGION_W-1:0] REGION_SPIRIT  = 4'b0010;
  localparam logic [REGION_W-1:0] REGION_TILE    = 4'b0100;
  localparam logic [REGION_W-1:0] REGION_TEXTURE = 4'b1000;

  localparam int PAGE_HI = 15;
  localparam int PAGE_LO = 12;
  localparam int SUB_HI  = 11;
  localparam int SUB_LO  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_STALL = 2'd1,
    ARB_WRITE = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/gpu_wb_region_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpu_wb_region_decoder: address bits 15:8 to one-hot GPU region      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module gpu_wb_region_decoder
  import gpu_pkg::*;
(
  input  logic [PAGE_HI:SUB_LO]  adr_i,
  output logic [REGION_W-1:0]    region_o
);

  logic [PAGE_HI-PAGE_LO:0] page;
  logic [SUB_HI-SUB_LO:0]   sub;

  assign page = adr_i[PAGE_HI:PAGE_LO];
  assign sub  = adr_i[SUB_HI:SUB_LO];

  // Page 0 is split: its first 256-byte block holds the control registers
  always_comb begin
    region_o = REGION_TEXTURE;
    if (page == '0) begin
      region_o = (sub != '0) ? REGION_SPIRIT : REGION_CR;
    end else if (page == 4'd1) begin
      region_o = REGION_TILE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpu_wb_arbiter: two-master Wishbone write arbiter for GPU memories  |
// | Define GPU_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module gpu_wb_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,

  input  logic              i_render_busy,

  output logic              o_cr_we,
  output logic              o_spirit_we,
  output logic              o_tile_we,
  output logic              o_texture_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wsel,
  output logic [1:0]        o_grant
);

  arb_state_e              state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic [ADDR_W-1:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [3:0]              wsel_q, wsel_d;
  logic                    we_q, we_d;
  logic [REGION_W-1:0]     region_q, region_d;
  logic [REGION_W-1:0]     wstb_q, wstb_d;
  logic [1:0]              ack_q, ack_d;

  logic                    req0, req1;
  logic                    win_m1;
  logic                    owner_cyc;
  logic [ADDR_W-1:0]       req_adr;
  logic [REGION_W-1:0]     req_region;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign owner_cyc = grant_q[1] ? m1_cyc_i : m0_cyc_i;

`ifdef GPU_ARB_ROUND_ROBIN_EN
  logic last_m1_q;

  // WRITE always advances to ACK, so this samples the owner as ACK is entered
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      last_m1_q <= 1'b1;
    end else if (state_q == ARB_WRITE) begin
      last_m1_q <= grant_q[1];
    end
  end

  always_comb begin
    win_m1 = req1 & ~req0;
    if (req0 && req1) begin
      win_m1 = ~last_m1_q;
    end
  end
`else
  always_comb begin
    win_m1 = req1 & ~req0;
  end
`endif

  assign req_adr = win_m1 ? m1_adr_i : m0_adr_i;

  gpu_wb_region_decoder u_region_dec (
    .adr_i    (req_adr[PAGE_HI:SUB_LO]),
    .region_o (req_region)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wsel_d   = wsel_q;
    we_d     = we_q;
    region_d = region_q;

    case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          grant_d  = win_m1 ? 2'b10 : 2'b01;
          waddr_d  = req_adr;
          wdata_d  = win_m1 ? m1_dat_i : m0_dat_i;
          wsel_d   = win_m1 ? m1_sel_i : m0_sel_i;
          we_d     = win_m1 ? m1_we_i  : m0_we_i;
          region_d = req_region;
          // Only CR writes collide with a render; everything else proceeds
          if (we_d && (region_d == REGION_CR) && i_render_busy) begin
            state_d = ARB_STALL;
          end else begin
            state_d = ARB_WRITE;
          end
        end
      end
      ARB_STALL: begin
        if (!owner_cyc) begin
          state_d = ARB_IDLE;
          grant_d = 2'b00;
        end else if (!i_render_busy) begin
          state_d = ARB_WRITE;
        end
      end
      ARB_WRITE: begin
        state_d = ARB_ACK;
      end
      ARB_ACK: begin
        state_d = ARB_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered
    wstb_d = ((state_d == ARB_WRITE) && we_d) ? region_d : '0;
    ack_d  = (state_d == ARB_ACK) ? grant_d : 2'b00;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= 2'b00;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wsel_q   <= '0;
      we_q     <= 1'b0;
      region_q <= '0;
      wstb_q   <= '0;
      ack_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wsel_q   <= wsel_d;
      we_q     <= we_d;
      region_q <= region_d;
      wstb_q   <= wstb_d;
      ack_q    <= ack_d;
    end
  end

  assign o_cr_we      = wstb_q[0];
  assign o_spirit_we  = wstb_q[1];
  assign o_tile_we    = wstb_q[2];
  assign o_texture_we = wstb_q[3];
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_wsel       = wsel_q;
  assign o_grant      = grant_q;
  assign m0_ack_o     = ack_q[0];
  assign m1_ack_o     = ack_q[1];
  assign m0_dat_o     = '0;
  assign m1_dat_o     = '0;

endmodule
`default_nettype wire

// File: doc/gpu_wb_arbiter.md
# gpu_wb_arbiter

Two-master Wishbone write arbiter for the GPU's memory-mapped resources: control registers, spirit position memory, tile map and texture memory. Replaces the free-running divide-by-two bus enable in front of those memories. Shares the single write port between the CPU master (m0) and the sprite/tile DMA master (m1). Decodes the target region and stalls control-register writes while a tile render is in flight.

## Interface
- ADDR_W, 27, Wishbone address width (both masters, downstream).
- DATA_W, 32, Wishbone data width.
- clk_100MHz  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low; clock clk_100MHz.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  CPU master control.
- m0_sel_i  in  4  CPU byte select.
- m0_adr_i  in  ADDR_W  CPU address.
- m0_dat_i  in  DATA_W  CPU write data.
- m0_dat_o  out  DATA_W  CPU read data, always 0 (write-only GPU space).
- m0_ack_o  out  1  CPU acknowledge.
- m1_* : identical set for the DMA master.
- i_render_busy  in  1  high while the tile controller has a render in flight.
- o_cr_we, o_spirit_we, o_tile_we, o_texture_we  out  1 each  single-cycle region write strobes.
- o_waddr  out  ADDR_W  latched write address.
- o_wdata  out  DATA_W  latched write data.
- o_wsel  out  4  latched byte select.
- o_grant  out  2  one-hot current owner; 00 when idle.

## Operation
- A request exists when cyc_i & stb_i are both high.
- States: IDLE, STALL, WRITE, ACK.
- IDLE, no request: stay in IDLE.
- IDLE with a request: arbitrate. Latch adr, dat, sel, we and the winner into o_waddr, o_wdata, o_wsel and o_grant.
  - Next state is STALL if the latched access is a CR write and i_render_busy=1.
  - Otherwise next state is WRITE.
- STALL:
  - Winner drops cyc: go to IDLE, no write strobe, no ack, o_grant=00.
  - Otherwise, i_render_busy=0: go to WRITE.
  - Otherwise: hold.
- WRITE: if we was latched high, assert exactly one region strobe for one cycle. Go to ACK.
- ACK: assert the winner's ack_o for one cycle. Go to IDLE; o_grant clears.
- Reads (we=0) take the same path, with no strobe; dat_o=0.
- Region decode on adr[15:12]:
  - 0 with adr[11:8]!=0 → spirit.
  - 0 with adr[11:8]=0 → CR.
  - 1 → tile.
  - Anything else → texture.
- Dropping cyc in WRITE or ACK does not cancel the access: the write is already committed and ack still pulses.
- A request on the non-owning master waits. Its ack_o stays 0.
- Reset mid-transfer returns to IDLE and clears every output and last_grant. A write in progress is lost.

## Timing
- Reset values: all strobes 0, both ack_o 0, both dat_o 0, o_grant 00, o_waddr/o_wdata/o_wsel 0, state IDLE.
- Unstalled access: request sampled in IDLE at cycle 0, strobe in cycle 1, ack in cycle 2, IDLE again in cycle 3.
- Throughput: one access per 3 cycles.
- A master keeping stb high after ack is sampled as a new request in the cycle-3 IDLE.
- A stalled CR write adds one cycle per cycle of i_render_busy seen in STALL. The strobe comes one cycle after busy falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- GPU_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - Register last_grant, reset value m1, so m0 wins the first tie.
  - On a simultaneous request, the master not in last_grant wins. last_grant updates when ACK is entered.
- Undefined: fixed priority. m0 always wins ties; m1 is served only when m0 is idle. The last_grant register is absent.

## Structure
- The gpu_pkg shared package holds:
  - the region codes (REGION_CR, REGION_SPIRIT, REGION_TILE, REGION_TEXTURE);
  - the arbiter state enum;
  - the address-field constants (bits 15:12 and 11:8).
- One sub-module, gpu_wb_region_decoder: combinational address → one-hot region. It is reused by the bus monitor in the bench.

## Test plan
- m0 writes 0xDEADBEEF to address 0x0002000 (texture), sel=F → o_texture_we pulses in cycle 1 with o_wdata=0xDEADBEEF; m0_ack_o pulses in cycle 2; other strobes stay 0.
- m0 and m1 request in the same cycle, both to tile 0x0001004:
  - with the macro: m0 is acked first, then m1, and the next tie goes to m1;
  - without the macro: m0 always wins, m1 is acked after m0 goes idle.
- m1 writes CR at 0x0000003 with i_render_busy=1 for 5 cycles → o_grant=10 throughout, o_cr_we pulses the cycle after busy falls, then ack.
- Stalled CR write and the master drops cyc during the stall → return to IDLE, no o_cr_we, no ack, o_grant=00.
- m0 read of 0x0000100 (spirit) → m0_ack_o in cycle 2, m0_dat_o=0, no strobe.
- reset_n asserted during WRITE → all outputs 0 the next cycle; a new m1 request after release is served normally.
